// File: rtl/fpa_pkg.sv
// Shared definitions for the floating-point adder operand packer.
// Frame layout is big-endian: A occupies the upper word of the 64-bit frame.
package fpa_pkg;

   localparam int FRAME_BYTES = 8;
   localparam int FRAME_W     = FRAME_BYTES * 8;
   localparam int IDX_W       = 3;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

   localparam int OPND_W = 32;
   localparam int A_LSB  = 32;
   localparam int B_LSB  = 0;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DROP
   } state_t;

endpackage

// File: rtl/fpa_strobe_delay.sv
// LATENCY-deep single-bit delay line.
// It clears asynchronously so that a reset cancels any in-flight pulse.
module fpa_strobe_delay #(
   parameter int LATENCY = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   generate
      if (LATENCY == 1) begin : g_one
         always_ff @(posedge clk or posedge rst) begin
            if (rst) q <= 1'b0;
            else     q <= d;
         end
      end else begin : g_many
         logic [LATENCY-1:0] sr;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) sr <= '0;
            else     sr <= {sr[LATENCY-2:0], d};
         end
         assign q = sr[LATENCY-1];
      end
   endgenerate

endmodule

// File: rtl/fpa_operand_packer.sv
// Assembles 8-byte frames into operand pairs A/B for the registered FP adder wrapper.
// Bad frames are counted and dropped; the operands are held until the next good frame arrives.
//
// state   | meaning
// IDLE    | no frame in progress, waiting for byte0
// COLLECT | bytes 1..7 of a frame being gathered into the shadow
// DROP    | over-long frame, discarding bytes until in_last
module fpa_operand_packer
   import fpa_pkg::*;
#(
   parameter int LATENCY = 2,
   parameter int ERR_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic [OPND_W-1:0] number_A,
   output logic [OPND_W-1:0] number_B,
   output logic              op_strobe,
   output logic              res_strobe,
   output logic              frame_err,
   output logic [ERR_W-1:0]  err_count,
   output logic              busy
);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   idx;
   logic [FRAME_W-9:0] shadow;
   logic [FRAME_W-1:0] frame;
   logic               store, load, err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      store     = 1'b0;
      load      = 1'b0;
      err       = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (in_last) begin
                  err = 1'b1;
               end else begin
                  store     = 1'b1;
                  state_nxt = COLLECT;
               end
            end
         end
         COLLECT: begin
            if (in_valid) begin
               if (idx == LAST_IDX) begin
                  if (in_last) begin
                     load      = 1'b1;
                     state_nxt = IDLE;
                  end else begin
                     err       = 1'b1;
                     state_nxt = DROP;
                  end
               end else if (in_last) begin
                  err       = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  store = 1'b1;
               end
            end
         end
         DROP: begin
            if (in_valid && in_last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Byte7 bypasses the shadow so the operands can load on the same edge it arrives.
   assign frame = {shadow, in_data};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         shadow    <= '0;
         number_A  <= '0;
         number_B  <= '0;
         op_strobe <= 1'b0;
         frame_err <= 1'b0;
         err_count <= '0;
      end else begin
         op_strobe <= load;
         frame_err <= err;
         if (store) begin
            idx    <= idx + 1'b1;
            shadow <= {shadow[FRAME_W-17:0], in_data};
         end else if (state_nxt != COLLECT) begin
            idx <= '0;
         end
         if (load) begin
            number_A <= frame[A_LSB +: OPND_W];
            number_B <= frame[B_LSB +: OPND_W];
         end
         if (err && (err_count != {ERR_W{1'b1}}))
            err_count <= err_count + 1'b1;
      end
   end

   assign busy = (state != IDLE);

   fpa_strobe_delay #(
      .LATENCY (LATENCY)
   ) u_res_delay (
      .clk (clk),
      .rst (rst),
      .d   (op_strobe),
      .q   (res_strobe)
   );

endmodule
